rs_age_multi_cdb: RTL



---
 rtl/rs_age_multi_cdb_if.sv | 52 +++++
 rtl/rs_age_multi_cdb.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rs_age_multi_cdb_if.sv
// Bundle between Decoder/CDB/ALU and the ALU reservation station.
// master = surrounding pipeline (drives issue, CDB, ALU ready); slave = the station.
interface rs_age_multi_cdb_if #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4,
  parameter int NCDB  = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   rdy;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_op;
  logic [6:0]             in_type;
  logic                   in_op_other;
  logic [31:0]            in_v1;
  logic [31:0]            in_v2;
  logic                   in_dep1;
  logic                   in_dep2;
  logic [ROB_W-1:0]       in_q1;
  logic [ROB_W-1:0]       in_q2;
  logic [ROB_W-1:0]       in_rob_id;
  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*ROB_W-1:0]  cdb_rob_id;
  logic [NCDB*32-1:0]     cdb_value;
  logic                   out_valid;
  logic                   out_ready;
  logic [2:0]             out_op;
  logic [6:0]             out_type;
  logic                   out_op_other;
  logic [31:0]            out_v1;
  logic [31:0]            out_v2;
  logic [ROB_W-1:0]       out_rob_id;
  logic [CW-1:0]          count;

  modport master (
    output rdy, flush, in_valid, in_op, in_type, in_op_other, in_v1, in_v2,
           in_dep1, in_dep2, in_q1, in_q2, in_rob_id,
           cdb_valid, cdb_rob_id, cdb_value, out_ready,
    input  in_ready, out_valid, out_op, out_type, out_op_other, out_v1, out_v2,
           out_rob_id, count
  );

  modport slave (
    input  rdy, flush, in_valid, in_op, in_type, in_op_other, in_v1, in_v2,
           in_dep1, in_dep2, in_q1, in_q2, in_rob_id,
           cdb_valid, cdb_rob_id, cdb_value, out_ready,
    output in_ready, out_valid, out_op, out_type, out_op_other, out_v1, out_v2,
           out_rob_id, count
  );
endinterface

// File: rtl/rs_age_multi_cdb.sv
// Age-ordered ALU reservation station with NCDB-channel wakeup; RS_CDB_BYPASS_EN adds insert-cycle CDB capture.
// Latency: ready entry reaches the registered output one edge after it becomes ready.
// Backpressure: output holds while out_ready=0; in_ready drops when DEPTH entries are occupied.
module rs_age_multi_cdb #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4,
  parameter int NCDB  = 2
) (
  input logic           i_clk,
  input logic           i_rst_n,
  rs_age_multi_cdb_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]       op;
    logic [6:0]       typ;
    logic             op_other;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [ROB_W-1:0] rob_id;
  } pay_t;

  logic [DEPTH-1:0] r_busy, r_dep1, r_dep2;
  pay_t             r_pay   [DEPTH];
  logic [ROB_W-1:0] r_q1    [DEPTH];
  logic [ROB_W-1:0] r_q2    [DEPTH];
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_out_valid;
  pay_t             r_out;

  logic [DEPTH-1:0] w_hit1, w_hit2, w_ready, w_blocked, w_sel, w_free_oh;
  logic [31:0]      w_val1 [DEPTH];
  logic [31:0]      w_val2 [DEPTH];
  pay_t             w_sel_pay, w_ins_pay;
  logic             w_ins_dep1, w_ins_dep2, w_in_ready, w_ins, w_load;

  // Lowest channel index wins when several channels carry the same tag.
  function automatic logic [32:0] f_cdb(input logic [ROB_W-1:0]      tag,
                                        input logic [NCDB-1:0]       vld,
                                        input logic [NCDB*ROB_W-1:0] ids,
                                        input logic [NCDB*32-1:0]    vals);
    f_cdb = '0;
    for (int c = NCDB - 1; c >= 0; c--) begin
      if (vld[c] && ids[c*ROB_W +: ROB_W] == tag) f_cdb = {1'b1, vals[c*32 +: 32]};
    end
  endfunction

  always_comb begin
    w_blocked = '0;
    w_free_oh = '0;
    w_sel_pay = '0;
    for (int i = 0; i < DEPTH; i++) begin
      {w_hit1[i], w_val1[i]} = f_cdb(r_q1[i], bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
      {w_hit2[i], w_val2[i]} = f_cdb(r_q2[i], bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
      w_ready[i] = r_busy[i] && !r_dep1[i] && !r_dep2[i];
    end
    // An entry is blocked if any older entry is also ready.
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (w_ready[j] && r_older[j][i]) w_blocked[i] = 1'b1;
      end
    end
    w_sel = w_ready & ~w_blocked;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel[i]) w_sel_pay = w_sel_pay | r_pay[i];
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_oh    = '0;
        w_free_oh[i] = 1'b1;
      end
    end
  end

  assign w_in_ready = (r_count != CW'(DEPTH));
  assign w_ins      = bus.in_valid && w_in_ready && !bus.flush;
  assign w_load     = (|w_sel) && (!r_out_valid || bus.out_ready);

`ifdef RS_CDB_BYPASS_EN
  logic        w_bhit1, w_bhit2;
  logic [31:0] w_bval1, w_bval2;
  always_comb begin
    {w_bhit1, w_bval1} = f_cdb(bus.in_q1, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
    {w_bhit2, w_bval2} = f_cdb(bus.in_q2, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
    w_ins_dep1 = bus.in_dep1 && !w_bhit1;
    w_ins_dep2 = bus.in_dep2 && !w_bhit2;
    w_ins_pay  = '{op: bus.in_op, typ: bus.in_type, op_other: bus.in_op_other,
                   v1: (bus.in_dep1 && w_bhit1) ? w_bval1 : bus.in_v1,
                   v2: (bus.in_dep2 && w_bhit2) ? w_bval2 : bus.in_v2,
                   rob_id: bus.in_rob_id};
  end
`else
  always_comb begin
    w_ins_dep1 = bus.in_dep1;
    w_ins_dep2 = bus.in_dep2;
    w_ins_pay  = '{op: bus.in_op, typ: bus.in_type, op_other: bus.in_op_other,
                   v1: bus.in_v1, v2: bus.in_v2, rob_id: bus.in_rob_id};
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy      <= '0;
      r_dep1      <= '0;
      r_dep2      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pay[i]   <= '0;
        r_q1[i]    <= '0;
        r_q2[i]    <= '0;
        r_older[i] <= '0;
      end
    end else if (bus.rdy) begin
      if (bus.flush) begin
        r_busy      <= '0;
        r_count     <= '0;
        r_out_valid <= 1'b0;
        for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
      end else begin
        r_count <= r_count + CW'(w_ins) - CW'(w_load);
        if (w_load) begin
          r_out_valid <= 1'b1;
          r_out       <= w_sel_pay;
        end else if (bus.out_ready) begin
          r_out_valid <= 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (w_load && w_sel[i]) r_busy[i] <= 1'b0;
          if (r_busy[i] && r_dep1[i] && w_hit1[i]) begin
            r_pay[i].v1 <= w_val1[i];
            r_dep1[i]   <= 1'b0;
          end
          if (r_busy[i] && r_dep2[i] && w_hit2[i]) begin
            r_pay[i].v2 <= w_val2[i];
            r_dep2[i]   <= 1'b0;
          end
          // New slot k: older[k][*]=0, older[*][k]=busy[*].
          if (w_ins) begin
            r_older[i] <= w_free_oh[i] ? '0
                        : ((r_older[i] & ~w_free_oh) | (r_busy[i] ? w_free_oh : '0));
          end
          if (w_ins && w_free_oh[i]) begin
            r_busy[i]  <= 1'b1;
            r_pay[i]   <= w_ins_pay;
            r_dep1[i]  <= w_ins_dep1;
            r_dep2[i]  <= w_ins_dep2;
            r_q1[i]    <= bus.in_q1;
            r_q2[i]    <= bus.in_q2;
          end
        end
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.count        = r_count;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_op       = r_out.op;
  assign bus.out_type     = r_out.typ;
  assign bus.out_op_other = r_out.op_other;
  assign bus.out_v1       = r_out.v1;
  assign bus.out_v2       = r_out.v2;
  assign bus.out_rob_id   = r_out.rob_id;
endmodule
